// File: rtl/ray_scheduler.sv
// ray_scheduler: per-frame ray column issue, render drain and buffer swap.
// Optional drain watchdog is built when RAY_SCHEDULER_WATCHDOG_EN is defined.
module ray_scheduler #(
  parameter int SCREEN_WIDTH    = 320,
  parameter int WATCHDOG_CYCLES = 1237500
) (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic       frame_start_in,
  input  logic       ray_tready_in,
  output logic       ray_tvalid_out,
  output logic [8:0] ray_hcount_out,
  input  logic       render_done_in,
  output logic       pose_latch_out,
  output logic       swap_out,
  output logic       busy_out,
  output logic       frame_drop_out,
  output logic [7:0] drop_count_out,
  output logic       timeout_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WAIT_SWAP
  } state_e;

  localparam logic [8:0] LAST_COL = 9'(SCREEN_WIDTH - 1);

  state_e     state_q, state_d;
  logic [8:0] hcount_q, hcount_d;
  logic       tvalid_q, tvalid_d;
  logic       pose_q, pose_d;
  logic       swap_q, swap_d;
  logic       busy_q, busy_d;
  logic       drop_q, drop_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       timeout_q, timeout_d;
  logic       xfer;
  logic       wd_expired;

  assign xfer = tvalid_q && ray_tready_in;

`ifdef RAY_SCHEDULER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Held at zero outside DRAIN so every drain starts a fresh count
  always_comb begin
    wd_d = wd_q;
    if (state_q != DRAIN) begin
      wd_d = '0;
    end else if (!wd_expired) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_expired = (state_q == DRAIN) && (wd_q == WD_LAST);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hcount_d   = hcount_q;
    tvalid_d   = tvalid_q;
    pose_d     = 1'b0;
    swap_d     = 1'b0;
    timeout_d  = timeout_q;
    drop_d     = frame_start_in &&
                 (state_q == ISSUE || state_q == DRAIN);
    drop_cnt_d = drop_cnt_q;
    if (drop_d && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_d  = ISSUE;
          hcount_d = '0;
          tvalid_d = 1'b1;
          pose_d   = 1'b1;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (hcount_q == LAST_COL) begin
            state_d  = DRAIN;
            tvalid_d = 1'b0;
          end else begin
            hcount_d = hcount_q + 9'd1;
          end
        end
      end
      DRAIN: begin
        if (render_done_in) begin
          state_d = WAIT_SWAP;
        end else if (wd_expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      WAIT_SWAP: begin
        if (frame_start_in) begin
          state_d  = ISSUE;
          hcount_d = '0;
          tvalid_d = 1'b1;
          pose_d   = 1'b1;
          swap_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      hcount_q   <= '0;
      tvalid_q   <= 1'b0;
      pose_q     <= 1'b0;
      swap_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      tvalid_q   <= tvalid_d;
      pose_q     <= pose_d;
      swap_q     <= swap_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ray_tvalid_out = tvalid_q;
  assign ray_hcount_out = hcount_q;
  assign pose_latch_out = pose_q;
  assign swap_out       = swap_q;
  assign busy_out       = busy_q;
  assign frame_drop_out = drop_q;
  assign drop_count_out = drop_cnt_q;
  assign timeout_out    = timeout_q;

endmodule

// File: doc/ray_scheduler.md
RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 The block SHALL have parameter SCREEN_WIDTH, default 320: number of ray columns issued per frame.
REQ-002 The block SHALL have parameter WATCHDOG_CYCLES, default 1237500: maximum number of drain cycles, equal to one 720p frame.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port pixel_clk_in, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port frame_start_in, input, 1 bit: one-cycle pulse at the video last-pixel boundary.
REQ-007 The block SHALL have port ray_tready_in, input, 1 bit: ray-calculation/DDA-in path accepts a column.
REQ-008 The block SHALL have port ray_tvalid_out, output, 1 bit: ray_hcount_out is valid.
REQ-009 The block SHALL have port ray_hcount_out, output, 9 bits: column index to render.
REQ-010 The block SHALL have port render_done_in, input, 1 bit: one-cycle pulse from the transformation stage after the last pixel of a frame is written.
REQ-011 The block SHALL have port pose_latch_out, output, 1 bit: one-cycle pulse telling the controller to freeze the pose for this frame.
REQ-012 The block SHALL have port swap_out, output, 1 bit: one-cycle pulse commanding the frame-buffer swap.
REQ-013 The block SHALL have port busy_out, output, 1 bit: high in states ISSUE and DRAIN.
REQ-014 The block SHALL have port frame_drop_out, output, 1 bit: one-cycle pulse when a frame start is missed.
REQ-015 The block SHALL have port drop_count_out, output, 8 bits: saturating count of dropped frames.
REQ-016 The block SHALL have port timeout_out, output, 1 bit: sticky watchdog error flag.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and WAIT_SWAP; all outputs SHALL be registered.
REQ-018 In IDLE, a frame_start_in pulse at cycle N SHALL give state=ISSUE, hcount=0 and pose_latch_out=1 at cycle N+1.
REQ-019 In ISSUE, ray_tvalid_out SHALL be 1; a column transfers on each cycle where ray_tvalid_out and ray_tready_in are both 1.
REQ-020 While ray_tready_in=0, ray_tvalid_out and ray_hcount_out SHALL stay stable; valid SHALL never drop without a transfer.
REQ-021 On a transfer with hcount<SCREEN_WIDTH-1, hcount SHALL increment by 1, allowing back-to-back transfers at one column per cycle.
REQ-022 On a transfer with hcount=SCREEN_WIDTH-1, the FSM SHALL go to DRAIN and ray_tvalid_out=0 next cycle; hcount SHALL never issue SCREEN_WIDTH.
REQ-023 In DRAIN, render_done_in SHALL move the FSM to WAIT_SWAP.
REQ-024 render_done_in SHALL be ignored in IDLE, ISSUE and WAIT_SWAP.
REQ-025 In WAIT_SWAP, a frame_start_in pulse SHALL, in the same next cycle: pulse swap_out, pulse pose_latch_out, and enter ISSUE with hcount=0.
REQ-026 A frame_start_in pulse in ISSUE or DRAIN SHALL pulse frame_drop_out next cycle, increment drop_count_out saturating at 255, and leave FSM, hcount and outputs otherwise unchanged.
REQ-027 If frame_start_in and render_done_in are both high in DRAIN, the block SHALL count a drop and go to WAIT_SWAP; it SHALL NOT swap until the next frame_start_in.
REQ-028 swap_out SHALL never pulse before render_done_in has been received for the current frame.

Reset
REQ-029 rst_in=0 SHALL immediately set state=IDLE, hcount=0, and all outputs to 0, including drop_count_out and timeout_out, regardless of clock.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no swap_out pulse.
REQ-031 After reset release, the first frame_start_in SHALL begin a new frame per REQ-018.

Configuration
REQ-032 Macro RAY_SCHEDULER_WATCHDOG_EN defined: a drain-cycle counter SHALL clear on DRAIN entry; if it reaches WATCHDOG_CYCLES without render_done_in, the FSM SHALL go to IDLE, set timeout_out=1 (sticky until reset), and issue no swap.
REQ-033 Macro RAY_SCHEDULER_WATCHDOG_EN undefined: no counter SHALL be built, timeout_out SHALL be tied to 0, and DRAIN SHALL wait indefinitely.

Verification
REQ-034 Scenario: ray_tready_in=1 constantly, frame_start_in pulse -> hcount 0..319 on 320 consecutive cycles, then DRAIN, pose_latch_out exactly one pulse.
REQ-035 Scenario: ray_tready_in low for 5 cycles at hcount=100 -> hcount_out held at 100 with valid=1, then resumes at 101; total transfers = 320.
REQ-036 Scenario: render_done_in in DRAIN, then frame_start_in -> swap_out and pose_latch_out pulse in the same cycle, ISSUE restarts at hcount=0.
REQ-037 Scenario: 300 frame_start_in pulses during ISSUE/DRAIN -> 300 frame_drop_out pulses, drop_count_out=255, no swap_out.
REQ-038 Scenario: rst_in=0 asserted at hcount=150 between clock edges -> outputs 0 immediately, no swap_out after release.
REQ-039 Scenario with RAY_SCHEDULER_WATCHDOG_EN and WATCHDOG_CYCLES=100: no render_done_in -> timeout_out=1 and state IDLE at 100 drain cycles.
